xpb_lut_engine: RTL and testbench

XPB_LUT_ENGINE -- requirements
Module: xpb_lut_engine

---
 rtl/xpb_lut_engine.sv | 151 +++++++++++++++
 tb/tb_xpb_lut_engine.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/xpb_lut_engine.sv
// Multi-channel registered lookup table with a single write port and 1-cycle lookups.
// Define XPB_LUT_GEN_EN to add the on-chip modular-multiple table generator.
module xpb_lut_engine #(
  parameter int unsigned DATA_W = 1024,
  parameter int unsigned SEL_W  = 5,
  parameter int unsigned NUM_CH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef XPB_LUT_GEN_EN
  input  logic                     gen_start,
  input  logic [DATA_W-1:0]        gen_base,
  input  logic [DATA_W-1:0]        gen_mod,
`endif
  input  logic                     wr_en,
  input  logic [SEL_W-1:0]         wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_CH-1:0]        lk_valid,
  input  logic [NUM_CH*SEL_W-1:0]  lk_sel,
  output logic                     lk_ready,
  output logic [NUM_CH-1:0]        out_valid,
  output logic [NUM_CH*DATA_W-1:0] data_out,
  output logic                     busy,
  output logic                     table_ok
);

  localparam int unsigned Depth = 2 ** SEL_W;

  logic [DATA_W-1:0] tbl_q [Depth];

  logic              gen_we;
  logic [SEL_W-1:0]  gen_idx;
  logic [DATA_W-1:0] gen_val;
  logic              gen_start_acc;
  logic              gen_done;
  logic              ext_we;

`ifdef XPB_LUT_GEN_EN
  typedef enum logic [0:0] {StIdle, StGen} gen_state_e;

  gen_state_e        state_q, state_d;
  logic [SEL_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] mod_q, mod_d;
  logic [DATA_W:0]   sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      acc_q   <= '0;
      base_q  <= '0;
      mod_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      base_q  <= base_d;
      mod_q   <= mod_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    acc_d         = acc_q;
    base_d        = base_q;
    mod_d         = mod_q;
    gen_start_acc = 1'b0;
    gen_we        = 1'b0;
    gen_done      = 1'b0;
    // One extra bit keeps acc + base exact before the conditional subtract.
    sum     = {1'b0, acc_q} + {1'b0, base_q};
    gen_val = (sum >= {1'b0, mod_q}) ? DATA_W'(sum - {1'b0, mod_q}) : sum[DATA_W-1:0];
    unique case (state_q)
      StIdle: begin
        if (gen_start) begin
          state_d       = StGen;
          idx_d         = SEL_W'(1);
          acc_d         = '0;
          base_d        = gen_base;
          mod_d         = gen_mod;
          gen_start_acc = 1'b1;
        end
      end
      StGen: begin
        gen_we = 1'b1;
        acc_d  = gen_val;
        idx_d  = idx_q + SEL_W'(1);
        // Termination depends only on the index, so bad base/mod still finish on time.
        if (idx_q == {SEL_W{1'b1}}) begin
          state_d  = StIdle;
          gen_done = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign gen_idx = idx_q;
  assign busy    = (state_q == StGen);
`else
  assign gen_we        = 1'b0;
  assign gen_idx       = '0;
  assign gen_val       = '0;
  assign gen_start_acc = 1'b0;
  assign gen_done      = 1'b0;
  assign busy          = 1'b0;
`endif

  assign lk_ready = !busy;
  // Entry 0 is never written, so it stays at its reset value of zero.
  assign ext_we   = wr_en && !busy && !gen_start_acc && (wr_addr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        tbl_q[i] <= '0;
      end
    end else if (gen_we) begin
      tbl_q[gen_idx] <= gen_val;
    end else if (ext_we) begin
      tbl_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      table_ok <= 1'b0;
    end else if (ext_we || gen_done) begin
      table_ok <= 1'b1;
    end
  end

  // Reads see pre-edge table contents, so a same-edge write is not visible yet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= '0;
      data_out  <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        out_valid[c] <= lk_valid[c] && !busy;
        if (lk_valid[c] && !busy) begin
          data_out[c*DATA_W +: DATA_W] <= tbl_q[lk_sel[c*SEL_W +: SEL_W]];
        end
      end
    end
  end

endmodule

// File: tb/tb_xpb_lut_engine.sv
// Table-driven bench for xpb_lut_engine (DATA_W=16, SEL_W=3, NUM_CH=2).
// Generator sequences run only when XPB_LUT_GEN_EN is defined.
module tb_xpb_lut_engine;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  lk_valid;
  logic [5:0]  lk_sel;
  logic        lk_ready;
  logic [1:0]  out_valid;
  logic [31:0] data_out;
  logic        busy;
  logic        table_ok;
`ifdef XPB_LUT_GEN_EN
  logic        gen_start;
  logic [15:0] gen_base;
  logic [15:0] gen_mod;
`endif

  int checks = 0;
  int errors = 0;

  xpb_lut_engine #(
    .DATA_W(16),
    .SEL_W (3),
    .NUM_CH(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef XPB_LUT_GEN_EN
    .gen_start(gen_start),
    .gen_base (gen_base),
    .gen_mod  (gen_mod),
`endif
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .lk_valid (lk_valid),
    .lk_sel   (lk_sel),
    .lk_ready (lk_ready),
    .out_valid(out_valid),
    .data_out (data_out),
    .busy     (busy),
    .table_ok (table_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic [1:0]  lv;
    logic [2:0]  s0;
    logic [2:0]  s1;
    logic [1:0]  ov;
    logic [15:0] d0;
    logic [15:0] d1;
    logic        ok;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One lookup on both channels, checked one edge later.
  task automatic lookup_both(input logic [2:0] sel, input logic [15:0] exp, input string name);
    @(negedge clk);
    wr_en    = 1'b0;
    lk_valid = 2'b11;
    lk_sel   = {sel, sel};
    @(posedge clk);
    #1;
    check({name, " ov"}, {30'd0, out_valid}, 32'd3);
    check({name, " d0"}, {16'd0, data_out[15:0]}, {16'd0, exp});
    check({name, " d1"}, {16'd0, data_out[31:16]}, {16'd0, exp});
  endtask

`ifdef XPB_LUT_GEN_EN
  task automatic run_gen(input logic [15:0] base, input logic [15:0] md,
                         input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2,
                         input logic [15:0] e3, input logic [15:0] e4, input logic [15:0] e5,
                         input logic [15:0] e6, input logic [15:0] e7);
    logic [15:0] exp_tbl [8];
    exp_tbl = '{e0, e1, e2, e3, e4, e5, e6, e7};
    @(negedge clk);
    gen_start = 1'b1;
    gen_base  = base;
    gen_mod   = md;
    lk_valid  = 2'b00;
    @(posedge clk);
    #1;
    check("gen start busy", {31'd0, busy}, 32'd1);
    check("gen start ready", {31'd0, lk_ready}, 32'd0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("gen busy cycle", {31'd0, busy}, 32'd1);
      gen_start = 1'b1;
      gen_base  = 16'h0001;
      lk_valid  = 2'b11;
      lk_sel    = 6'b011_011;
      @(posedge clk);
      #1;
      check("gen dropped lookup", {30'd0, out_valid}, 32'd0);
    end
    @(negedge clk);
    gen_start = 1'b0;
    lk_valid  = 2'b00;
    check("gen done busy", {31'd0, busy}, 32'd0);
    check("gen done table_ok", {31'd0, table_ok}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      lookup_both(3'(k), exp_tbl[k], "gen entry");
    end
  endtask
`endif

  initial begin
    rst      = 1'b1;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    lk_valid = '0;
    lk_sel   = '0;
`ifdef XPB_LUT_GEN_EN
    gen_start = 1'b0;
    gen_base  = '0;
    gen_mod   = '0;
`endif

    //               wr    wa    wd        lv     s0    s1    ov     d0        d1        ok
    vecs[0]  = '{1'b0, 3'd0, 16'h0000, 2'b11, 3'd0, 3'd1, 2'b11, 16'h0000, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0, 3'd0, 16'h0000, 2'b11, 3'd2, 3'd3, 2'b11, 16'h0000, 16'h0000, 1'b0};
    vecs[2]  = '{1'b0, 3'd0, 16'h0000, 2'b11, 3'd4, 3'd5, 2'b11, 16'h0000, 16'h0000, 1'b0};
    vecs[3]  = '{1'b0, 3'd0, 16'h0000, 2'b11, 3'd6, 3'd7, 2'b11, 16'h0000, 16'h0000, 1'b0};
    vecs[4]  = '{1'b1, 3'd3, 16'hBEEF, 2'b00, 3'd0, 3'd0, 2'b00, 16'h0000, 16'h0000, 1'b1};
    vecs[5]  = '{1'b0, 3'd0, 16'h0000, 2'b11, 3'd3, 3'd3, 2'b11, 16'hBEEF, 16'hBEEF, 1'b1};
    vecs[6]  = '{1'b1, 3'd0, 16'h1234, 2'b11, 3'd0, 3'd3, 2'b11, 16'h0000, 16'hBEEF, 1'b1};
    vecs[7]  = '{1'b0, 3'd0, 16'h0000, 2'b11, 3'd0, 3'd0, 2'b11, 16'h0000, 16'h0000, 1'b1};
    vecs[8]  = '{1'b1, 3'd5, 16'h1111, 2'b11, 3'd5, 3'd5, 2'b11, 16'h0000, 16'h0000, 1'b1};
    vecs[9]  = '{1'b0, 3'd0, 16'h0000, 2'b11, 3'd5, 3'd3, 2'b11, 16'h1111, 16'hBEEF, 1'b1};
    vecs[10] = '{1'b0, 3'd0, 16'h0000, 2'b10, 3'd3, 3'd5, 2'b10, 16'h1111, 16'h1111, 1'b1};
    vecs[11] = '{1'b0, 3'd0, 16'h0000, 2'b00, 3'd3, 3'd3, 2'b00, 16'h1111, 16'h1111, 1'b1};
    vecs[12] = '{1'b1, 3'd7, 16'hA5A5, 2'b11, 3'd7, 3'd2, 2'b11, 16'h0000, 16'h0000, 1'b1};
    vecs[13] = '{1'b0, 3'd0, 16'h0000, 2'b11, 3'd2, 3'd7, 2'b11, 16'h0000, 16'hA5A5, 1'b1};

    #12;
    check("reset out_valid", {30'd0, out_valid}, 32'd0);
    check("reset data_out", data_out, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset table_ok", {31'd0, table_ok}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("idle lk_ready", {31'd0, lk_ready}, 32'd1);

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      wr_en    = vecs[i].wr;
      wr_addr  = vecs[i].wa;
      wr_data  = vecs[i].wd;
      lk_valid = vecs[i].lv;
      lk_sel   = {vecs[i].s1, vecs[i].s0};
      @(posedge clk);
      #1;
      check($sformatf("vec%0d ov", i), {30'd0, out_valid}, {30'd0, vecs[i].ov});
      check($sformatf("vec%0d d0", i), {16'd0, data_out[15:0]}, {16'd0, vecs[i].d0});
      check($sformatf("vec%0d d1", i), {16'd0, data_out[31:16]}, {16'd0, vecs[i].d1});
      check($sformatf("vec%0d ok", i), {31'd0, table_ok}, {31'd0, vecs[i].ok});
      check($sformatf("vec%0d ready", i), {31'd0, lk_ready}, 32'd1);
    end

    // Asynchronous reset mid-operation clears everything without waiting for an edge.
    @(negedge clk);
    wr_en    = 1'b0;
    lk_valid = 2'b00;
    #2;
    rst = 1'b1;
    #1;
    check("async rst table_ok", {31'd0, table_ok}, 32'd0);
    check("async rst data_out", data_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    lookup_both(3'd3, 16'h0000, "post-rst entry3");
    lookup_both(3'd7, 16'h0000, "post-rst entry7");
    check("post-rst table_ok", {31'd0, table_ok}, 32'd0);

`ifdef XPB_LUT_GEN_EN
    run_gen(16'd5, 16'd13, 16'd0, 16'd5, 16'd10, 16'd2, 16'd7, 16'd12, 16'd4, 16'd9);
    run_gen(16'hFFF0, 16'hFFF1, 16'h0000, 16'hFFF0, 16'hFFEF, 16'hFFEE, 16'hFFED, 16'hFFEC,
            16'hFFEB, 16'hFFEA);

    // Abort generation with reset after its third entry write.
    @(negedge clk);
    gen_start = 1'b1;
    gen_base  = 16'd5;
    gen_mod   = 16'd13;
    @(posedge clk);
    @(negedge clk);
    gen_start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("gen abort busy before rst", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("gen abort busy", {31'd0, busy}, 32'd0);
    check("gen abort table_ok", {31'd0, table_ok}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      lookup_both(3'(k), 16'h0000, "gen abort entry");
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
